// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   N-channel, WIDTH-bit stream multiplexer. Every input and the output use a
//   valid/ready handshake. The channel is chosen either by software (mode 0,
//   via sel) or by a round-robin arbiter (mode 1). The output is a registered
//   one-deep buffer with 1-cycle latency. It can refill in the same cycle that
//   it drains, so a steady stream moves at full throughput.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   enable     1 = new words may be accepted; 0 = nothing accepted, output drains
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in mode 0
//   in_data    flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts when out_valid && out_ready
//   out_ch     source channel of out_data
//   xfer_count saturating 16-bit count of input transfers
//              (present only when RR_STREAM_MUX_CNT_EN is defined)
module rr_stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
`ifdef RR_STREAM_MUX_CNT_EN
  ,
  output logic [15:0]             xfer_count
`endif
);

  logic [SEL_W-1:0] rr_ptr;        // channel granted most recently in mode 1
  logic [SEL_W-1:0] grant;
  logic             grant_active;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  logic             xfer;

  // The buffer can take a word when it is empty, or when it is emptied in
  // this same cycle.
  assign load = !out_valid || out_ready;

  // Arbiter. In mode 0, sel values past the last channel match no loop index,
  // so they never produce a grant. In mode 1, the search starts one past the
  // last winner. That gives round-robin fairness.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    grant        = '0;
    grant_active = 1'b0;
    idx          = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant        = SEL_W'(i);
          grant_active = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!grant_active && in_valid[idx]) begin
          grant        = SEL_W'(idx);
          grant_active = 1'b1;
        end
      end
    end
  end

  // Ready decode and data select. The ready depends on rst_n here, so no
  // producer sees a handshake while reset is held.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
      in_ready[i] = rst_n && enable && load && grant_active && (grant == SEL_W'(i));
    end
  end

  assign xfer = |(in_valid & in_ready);

  // NOTE: reset is synchronous. Every register here is reset, including the
  // data word, so the bus reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      if (mode) begin
        rr_ptr <= grant;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_STREAM_MUX_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (xfer && xfer_count != 16'hFFFF) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (WIDTH=8, NUM_CH=4, SEL_W=2).
// Phase 1 applies a table of hand-derived vectors, each with its expected
// in_ready and the expected registered outputs after the edge.
// Phase 2 applies random traffic and compares it against a behavioural
// model built from the handshake rules.
// Phase 3 (only with RR_STREAM_MUX_CNT_EN) exercises the transfer counter.
module tb_rr_stream_mux;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
`ifdef RR_STREAM_MUX_CNT_EN
  logic [15:0]             xfer_count;
`endif

  rr_stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef RR_STREAM_MUX_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic       md;
    logic [1:0] s;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] rdy;   // expected in_ready before the edge
    logic       ov;    // expected out_valid after the edge
    logic [1:0] och;   // expected out_ch after the edge
    logic [7:0] od;    // expected out_data after the edge
  } vec_t;

  vec_t vecs[24];

  // ---------------- behavioural model ----------------
  int         m_valid;
  int         m_ch;
  int         m_ptr;
  logic [7:0] m_data;
  int         m_cnt;

  // Returns the channel that should win, or -1 if none.
  function automatic int model_grant();
    if (!mode) begin
      if (int'(sel) < NUM_CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    int         g;
    logic [3:0] er;
    #1;
    g  = model_grant();
    er = (rst_n && enable && (m_valid == 0 || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0;
    check("rand_in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 8'h00; m_ch = 0; m_ptr = NUM_CH - 1; m_cnt = 0;
    end else if (er != 4'b0) begin
      m_valid = 1;
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_ch    = g;
      if (mode) m_ptr = g;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    #1;
    check("rand_out_valid", 32'(out_valid), 32'(m_valid));
    check("rand_out_data", 32'(out_data), 32'(m_data));
    check("rand_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef RR_STREAM_MUX_CNT_EN
    check("rand_xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    // Fixed words for the table: ch0=10 ch1=11 ch2=A5 ch3=13
    //             rst en md s  iv     ordy  rdy   ov och od
    vecs[0]  = '{0, 1, 1, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h00}; // reset held, all valid
    vecs[1]  = '{0, 1, 1, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h00};
    vecs[2]  = '{1, 1, 1, 0, 4'hF, 1, 4'b0001, 1, 0, 8'h10}; // rr: ch0 first
    vecs[3]  = '{1, 1, 1, 0, 4'hF, 1, 4'b0010, 1, 1, 8'h11};
    vecs[4]  = '{1, 1, 1, 0, 4'hF, 1, 4'b0100, 1, 2, 8'hA5};
    vecs[5]  = '{1, 1, 1, 0, 4'hF, 1, 4'b1000, 1, 3, 8'h13};
    vecs[6]  = '{1, 1, 1, 0, 4'hF, 1, 4'b0001, 1, 0, 8'h10}; // wraps
    vecs[7]  = '{1, 1, 1, 0, 4'hF, 1, 4'b0010, 1, 1, 8'h11};
    vecs[8]  = '{1, 1, 0, 2, 4'h4, 1, 4'b0100, 1, 2, 8'hA5}; // mode 0, sel=2
    vecs[9]  = '{1, 1, 0, 3, 4'h4, 1, 4'b0000, 0, 2, 8'hA5}; // sel=3 invalid: drain
    vecs[10] = '{1, 1, 0, 3, 4'h4, 1, 4'b0000, 0, 2, 8'hA5};
    vecs[11] = '{1, 1, 1, 0, 4'hF, 0, 4'b0100, 1, 2, 8'hA5}; // load, then stall
    vecs[12] = '{1, 1, 1, 0, 4'hF, 0, 4'b0000, 1, 2, 8'hA5};
    vecs[13] = '{1, 1, 1, 0, 4'hF, 0, 4'b0000, 1, 2, 8'hA5};
    vecs[14] = '{1, 1, 1, 0, 4'hF, 0, 4'b0000, 1, 2, 8'hA5};
    vecs[15] = '{1, 1, 1, 0, 4'hF, 1, 4'b1000, 1, 3, 8'h13}; // release: next word
    vecs[16] = '{1, 0, 1, 0, 4'hF, 1, 4'b0000, 0, 3, 8'h13}; // enable=0 drains
    vecs[17] = '{1, 0, 1, 0, 4'hF, 1, 4'b0000, 0, 3, 8'h13};
    vecs[18] = '{1, 1, 1, 0, 4'hF, 1, 4'b0001, 1, 0, 8'h10};
    vecs[19] = '{1, 0, 1, 0, 4'hF, 0, 4'b0000, 1, 0, 8'h10}; // enable=0 in stall
    vecs[20] = '{1, 0, 1, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h10};
    vecs[21] = '{1, 1, 1, 0, 4'hF, 0, 4'b0010, 1, 1, 8'h11};
    vecs[22] = '{0, 1, 1, 0, 4'hF, 0, 4'b0000, 0, 0, 8'h00}; // reset discards word
    vecs[23] = '{1, 1, 1, 0, 4'h4, 1, 4'b0100, 1, 2, 8'hA5}; // ptr back to 3

    in_data = 32'h13A5_1110;
    for (int i = 0; i < 24; i++) begin
      rst_n     = vecs[i].rst;
      enable    = vecs[i].en;
      mode      = vecs[i].md;
      sel       = vecs[i].s;
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].och));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
    end

    // Random traffic against the model; the first cycle resets both.
    m_valid = 0; m_data = 8'h00; m_ch = 0; m_ptr = NUM_CH - 1; m_cnt = 0;
    rst_n = 1'b0;
    model_cycle();
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = SEL_W'($urandom_range(0, NUM_CH - 1));
      in_valid  = NUM_CH'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      model_cycle();
    end

`ifdef RR_STREAM_MUX_CNT_EN
    // Counter: reset, 5 transfers, saturation, reset again.
    rst_n = 1'b0; enable = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    @(posedge clk); #1;
    check("cnt_after_reset", 32'(xfer_count), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("cnt_five", 32'(xfer_count), 32'd5);
    repeat (65540) @(posedge clk);
    #1;
    check("cnt_saturate", 32'(xfer_count), 32'hFFFF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("cnt_cleared", 32'(xfer_count), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
